// File: rtl/ysyx_220053_ifu_pkg.sv
// rtl/ysyx_220053_ifu_pkg.sv - shared fetch/decode widths, reset vector and fetch-entry type
package ysyx_220053_ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_220053_fetch_fifo.sv
// rtl/ysyx_220053_fetch_fifo.sv - power-of-two instruction buffer with flush and same-cycle push/pop
module ysyx_220053_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // At full a push is only legal when the head leaves in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ysyx_220053_ifu.sv
// rtl/ysyx_220053_ifu.sv - instruction fetch: PC, credit-limited imem requests, redirect discard, sticky halt
module ysyx_220053_ifu
    import ysyx_220053_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic            halted;
    logic            credit_ok;
    logic            fire;
    logic            push;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign redirect_target = redirect_pc & ~64'h3;

    // Credits cover both in-flight beats and buffered entries, so responses always find room.
    assign credit_ok = (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH))
                    && (outstanding < CW'(MAX_OUTSTANDING));

    assign imem_req_valid = !rst && !halted && !halt && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign push            = imem_resp_valid && (discard == '0) && !redirect_valid;
    assign push_entry.pc   = resp_pc;
    assign push_entry.inst = imem_resp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            halted      <= 1'b0;
        end else begin
            if (halt) halted <= 1'b1;

            case ({fire, imem_resp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                // Everything still in flight belongs to the old stream; this cycle's beat is dropped too.
                pc      <= redirect_target;
                resp_pc <= redirect_target;
                discard <= outstanding - (imem_resp_valid ? CW'(1) : CW'(0));
            end else begin
                if (fire) pc <= pc + 64'd4;
                if (imem_resp_valid) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else               resp_pc <= resp_pc + 64'd4;
                end
            end
        end
    end

    ysyx_220053_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (inst_ready),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_o     = head_entry.inst;
    assign pc_o       = head_entry.pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (outstanding <= CW'(MAX_OUTSTANDING));
            assert (({1'b0, fifo_count} + {1'b0, outstanding}) <= (CW+1)'(FIFO_DEPTH));
            assert (discard <= outstanding);
        end
    end

endmodule
